// File: rtl/proc_in_fifo.sv
// Elastic sample buffer feeding processor input port 0 with a zero-latency read.
// It also keeps a sticky starvation flag and a saturating count of starved requests.
module proc_in_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 req_in,
    output logic signed [DW-1:0] io_in,
    output logic [AW:0]          count,
    output logic                 underflow,
    output logic [15:0]          underflow_cnt,
    input  logic                 clr_flags
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [DW-1:0] last_val_r;
    logic          underflow_r;
    logic [15:0]   underflow_cnt_r;

    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          starve_s;
    logic [15:0]   cnt_next_s;

    // Handshake and event decode; full/empty come from count only, never from req_in.
    always_comb begin
        ready_s    = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        starve_s   = 1'b0;
        cnt_next_s = underflow_cnt_r;
        if (!rst && (count_r < DEPTH_C)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        push_s   = s_valid && ready_s;
        pop_s    = req_in && (count_r != {(AW+1){1'b0}});
        starve_s = req_in && (count_r == {(AW+1){1'b0}});
        if (clr_flags) begin
            cnt_next_s = 16'd1;
        end else if (underflow_cnt_r != 16'hFFFF) begin
            cnt_next_s = underflow_cnt_r + 16'd1;
        end else begin
            cnt_next_s = underflow_cnt_r;
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // Pointers, occupancy and last-read word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            last_val_r <= {DW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                last_val_r <= mem_r[rd_ptr_r];
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + {{AW{1'b0}}, 1'b1};
            end else if (pop_s && !push_s) begin
                count_r <= count_r - {{AW{1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Starvation flag and counter; a same-cycle event beats clr_flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_r     <= 1'b0;
            underflow_cnt_r <= 16'd0;
        end else if (starve_s) begin
            underflow_r     <= 1'b1;
            underflow_cnt_r <= cnt_next_s;
        end else if (clr_flags) begin
            underflow_r     <= 1'b0;
            underflow_cnt_r <= 16'd0;
        end else begin
            underflow_r     <= underflow_r;
            underflow_cnt_r <= underflow_cnt_r;
        end
    end

    assign s_ready       = ready_s;
    assign io_in         = (count_r != {(AW+1){1'b0}}) ? mem_r[rd_ptr_r] : last_val_r;
    assign count         = count_r;
    assign underflow     = underflow_r;
    assign underflow_cnt = underflow_cnt_r;

endmodule

// File: doc/proc_in_fifo.md
Name: proc_in_fifo

Overview:
- Elastic input buffer between the sample source (ADC/frame reader, valid/ready) and the processor input port 0 (`proc_io_in` / `proc_req_in[0]`).
- Absorbs bursty sample arrival so the processor can pull one word per request cycle without the source tracking processor timing.
- Flags and counts starvation (a request with no data) for the filter-bank firmware.

Parameters:
- DW, 32, data width of samples and processor input word (two's complement).
- DEPTH, 16, FIFO depth in words; power of two, at least 2.
- AW, 4, pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- s_data  in  DW  signed sample from source.
- s_valid  in  1  source has a sample on s_data.
- s_ready  out  1  block can accept a sample this cycle.
- req_in  in  1  processor input request for port 0; each high cycle consumes one word.
- io_in  out  DW  signed word presented to processor input.
- count  out  AW+1  words currently stored (0..DEPTH).
- underflow  out  1  sticky starvation flag.
- underflow_cnt  out  16  number of starved requests, saturating.
- clr_flags  in  1  synchronous clear of underflow and underflow_cnt.

Behaviour:
- Reset (async assert, sync-to-clk release):
  - rd_ptr, wr_ptr and count are 0.
  - The last-value register last_val is 0.
  - underflow is 0 and underflow_cnt is 0.
  - io_in is 0.
  - s_ready is 0 while rst is high.
- Push fires on a rising edge when s_valid and s_ready:
  - mem[wr_ptr] takes s_data.
  - wr_ptr increments modulo DEPTH, wrapping from DEPTH-1 to 0.
- s_ready is high exactly when rst is low and count < DEPTH. It is combinational from registered count only, with no path from req_in.
- Full with a pop in the same cycle: no push that cycle; s_ready rises the following cycle.
- Pop fires on a rising edge when req_in and count != 0:
  - rd_ptr increments modulo DEPTH.
  - last_val takes mem[rd_ptr].
- io_in is combinational: mem[rd_ptr] when count != 0, else last_val.
  - The processor samples io_in in the same cycle it holds req_in high, with zero-latency read.
- Push-to-visibility latency when empty: a word pushed at edge N appears on io_in after edge N, so a request in cycle N+1 gets it.
- Push and request in the same cycle while empty:
  - The push completes.
  - No pop occurs; the word is not yet visible.
  - The request counts as an underflow and the processor sees last_val.
- Push and pop in the same cycle with 0 < count < DEPTH: both complete and count is unchanged.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- Underflow event, when req_in and count == 0 at the edge:
  - underflow is set to 1.
  - underflow_cnt increments, saturating at 16'hFFFF.
  - The pointers are unchanged.
- clr_flags:
  - Clears underflow to 0 and underflow_cnt to 0.
  - If an underflow event occurs in the same cycle, the event wins: underflow = 1 and underflow_cnt = 1.
- Reset mid-operation:
  - All stored data is discarded and pointers and counters return to reset values immediately.
  - A handshake in progress when rst asserts is lost.
  - The source must re-present the sample after release; s_ready = 0 during reset guarantees it is not counted as accepted.
- Pointer wrap: pointers are AW bits. Full versus empty is decided by count, not by pointer comparison.
- No combinational path from s_data to io_in except through mem, so there is no write-through.

Test Plan:
- Reset then push 5, -3, 7 in 3 consecutive cycles, no req -> count = 3, io_in = 5, s_ready = 1, underflow = 0.
- With that state, req_in high for 3 cycles -> processor sees 5, -3, 7 in order; count = 0; io_in holds 7 (last_val).
- Push DEPTH = 16 words 0..15 with s_valid held high -> s_ready falls after the 16th push and count = 16. A 17th word (99) held on s_data is not accepted until one req pop; then it is accepted and count = 16 again.
- Empty FIFO, req_in high for 3 cycles -> underflow = 1, underflow_cnt = 3, io_in = last_val, pointers unchanged. Then clr_flags together with another starved req -> underflow = 1, underflow_cnt = 1.
- Wrap stress: 40 cycles of simultaneous push/pop at count = 8 with incrementing data -> output sequence exactly matches input order across 2+ pointer wraps; count stays 8.
- Assert rst mid-stream with count = 6 -> count = 0, io_in = 0, s_ready = 0 during rst. After release, push 42 then req -> processor sees 42.
